md5_stream_ctrl: RTL and testbench
==================================

# md5_stream_ctrl

Byte-stream front end and sequencer for the `md5` core. It accepts a message one byte per handshake (e.g. from the UART receiver) and packs bytes into 128-bit little-endian beats. It generates MD5 padding and the 64-bit length field, drives the core's `newtext_i`/`load_i`/`data_i`, waits for `ready_o` after each 512-bit block, and presents the final digest to the consumer.

## Interface
- `LEN_W`, default 32: width of the message byte counter; bit length = `{count, 3'b000}` zero-extended to 64 bits.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `s_data` in 8: message byte.
- `s_valid` in 1: byte valid.
- `s_last` in 1: final byte of message.
- `s_keep` in 1: byte belongs to message; low is legal only with `s_last` (empty tail / empty message).
- `s_ready` out 1: controller accepts byte.
- `md5_newtext_o` out 1: one-cycle pulse to core `newtext_i`.
- `md5_load_o` out 1: one-cycle pulse to core `load_i`.
- `md5_data_o` out 128: beat to core `data_i`.
- `md5_ready_i` in 1: core `ready_o`.
- `md5_digest_i` in 128: core `data_o`.
- `digest_o` out 128, `digest_valid` out 1, `digest_ready` in 1: parallel digest; present only without `MD5_CTRL_BYTE_OUT_EN`.
- `m_data` out 8, `m_valid` out 1, `m_last` out 1, `m_ready` in 1: byte digest; present only with `MD5_CTRL_BYTE_OUT_EN`.
- `busy_o` out 1: high from first accepted byte until the digest is fully consumed.

## Operation
- States: IDLE, ACCEPT, PAD, LOAD, WAIT, OUT.
- IDLE:
  - `s_ready`=1.
  - On the first handshake, store the byte (if `s_keep`) and register `md5_newtext_o`=1 for the next cycle.
  - Go to ACCEPT, or to PAD if `s_last`.
- Byte placement:
  - Block offset o (0..63), beat b=o/16, k=o%16, w=k/4, j=k%4.
  - The byte is written to beat bits [96-32w+8j +: 8].
  - The first block word therefore sits in `md5_data_o[127:96]`, LSB byte first.
- ACCEPT:
  - `s_ready`=1; each kept byte increments the byte counter (wraps mod 2^LEN_W) and the offset.
  - When k reaches 16, go to LOAD.
  - On `s_last`, go to PAD; if `s_last` coincides with the beat filling, go to LOAD and mark pad pending.
- PAD, one byte per cycle, `s_ready`=0:
  - First write 0x80.
  - Then 0x00 until offset 56.
  - Offsets 56..63 carry bit length bytes 0..7, little-endian.
  - If 0x80 lands at offset ≥56, pad that block with zeros to 63, and write the length in the next block (zeros 0..55, length 56..63).
  - A full beat goes to LOAD.
- LOAD:
  - `md5_load_o`=1 for exactly one cycle with the beat on `md5_data_o`; clear the beat buffer.
  - If b==3 go to WAIT; else return to ACCEPT or PAD.
- WAIT:
  - `s_ready`=0 until `md5_ready_i`.
  - If the block was final, capture `md5_digest_i` and go to OUT; else return to ACCEPT/PAD at offset 0.
- OUT:
  - Hold the digest until consumed, then go to IDLE; `s_ready`=0 throughout.

## Timing
- Reset values: all outputs 0; internal state IDLE, counters 0.
- Once reset deasserts, `s_ready` goes 1 in IDLE.
- `md5_newtext_o` precedes the first `md5_load_o` by ≥1 cycle; they are never high together.
- LOAD beats within a block are spaced ≥1 cycle; after beat 3, no load until `md5_ready_i` is seen.
- No fixed core latency is assumed; only `md5_ready_i` advances WAIT. `md5_ready_i` outside WAIT is ignored.
- `s_valid` may gap arbitrarily; output is independent of gaps.
- Digest handshake is valid/ready: data stable while valid and not ready; transfer on valid&ready.
- Reset mid-operation: abandon everything immediately; the next message starts with a fresh `newtext`.

## Configuration
- `MD5_CTRL_BYTE_OUT_EN` defined: digest leaves as 16 bytes on `m_data` in standard MD5 order (byte i from `md5_digest_i` bits [96-32(i/4)+8(i%4) +: 8]); `m_last` is high on byte 15.
- Undefined: `digest_o` equals `md5_digest_i` verbatim (A in [127:96]), with `digest_valid`/`digest_ready`.

## Structure
- `md5_ctrl_pkg` holds:
  - the state enum;
  - constants `MD5_BLOCK_BYTES`=64, `MD5_BEAT_BYTES`=16, `MD5_LEN_OFFSET`=56, `MD5_PAD_BYTE`=8'h80;
  - function `md5_lane_lsb(k)` returning 96-32(k/4)+8(k%4).
- One sub-module: `md5_beat_packer`, a 128-bit buffer with byte-lane write, clear and full flag.

## Test plan
- Empty message (one beat: `s_last`=1, `s_keep`=0):
  - 1 newtext, 4 loads.
  - First beat 128'h00000080_0...0.
  - `digest_o` = d98c1dd4_04b2008f_980980e9_7e42f8ec.
- "abc":
  - First beat [127:96] = 32'h80636261.
  - Last beat [63:32] = 32'h00000018.
  - `digest_o` = 98500190_b04fd23c_7d3f96d6_727fe128.
- 56-byte "abcdbcde…nopq":
  - Two blocks, 8 loads; 0x80 at offset 56 and length 0x1C0 in block 2.
  - Digest bytes 8215ef0796a20bcaaae116d3876c664a.
- "abc" with `s_valid` toggling every cycle and `digest_ready` low 10 cycles:
  - Same digest, held stable; `s_ready`=0 until consumed.
- Reset asserted in WAIT:
  - All outputs 0 next edge.
  - "abc" afterwards gives the correct digest.
- With `MD5_CTRL_BYTE_OUT_EN`, "abc":
  - Bytes 90 01 50 98 … 72.
  - `m_last` only on the 16th byte.

Source files
------------

// File: rtl/md5_ctrl_pkg.sv
// Shared types and constants for the MD5 byte-stream controller.
// Optional build macro used by md5_stream_ctrl: MD5_CTRL_BYTE_OUT_EN.
package md5_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_PAD    = 3'd2,
        ST_LOAD   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_OUT    = 3'd5
    } md5_state_e;

    localparam int          MD5_BLOCK_BYTES = 64;
    localparam int          MD5_BEAT_BYTES  = 16;
    localparam int          MD5_LEN_OFFSET  = 56;
    localparam logic [7:0]  MD5_PAD_BYTE    = 8'h80;

    // Bit position of byte k (0..15) inside a 128-bit beat: word k/4 counts
    // down from the top, bytes inside a word are little-endian.
    function automatic logic [6:0] md5_lane_lsb(input logic [3:0] k);
        return 7'd96 - {k[3:2], 5'b00000} + {2'b00, k[1:0], 3'b000};
    endfunction

endpackage

// File: rtl/md5_beat_packer.sv
// 128-bit beat buffer with byte-lane writes, clear and a full flag that is
// raised when the last lane (15) is written.
module md5_beat_packer
    import md5_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en_i,
    input  logic [3:0]   lane_i,
    input  logic [7:0]   byte_i,
    input  logic         clr_i,
    output logic [127:0] beat_o,
    output logic         full_o
);

    logic [127:0] beat_q;
    logic         full_q;

    // Beat storage: clear has priority over a lane write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q <= 128'd0;
            full_q <= 1'b0;
        end else if (clr_i) begin
            beat_q <= 128'd0;
            full_q <= 1'b0;
        end else if (wr_en_i) begin
            beat_q[md5_lane_lsb(lane_i) +: 8] <= byte_i;
            if (lane_i == 4'(MD5_BEAT_BYTES - 1)) begin
                full_q <= 1'b1;
            end
        end
    end

    assign beat_o = beat_q;
    assign full_o = full_q;

endmodule

// File: rtl/md5_stream_ctrl.sv
// Byte-stream front end for the md5 core: packs bytes into beats, appends
// MD5 padding and bit length, sequences newtext/load/ready and returns the
// digest. Build macro MD5_CTRL_BYTE_OUT_EN selects a byte-serial digest port
// instead of the parallel 128-bit one.
module md5_stream_ctrl
    import md5_ctrl_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    input  logic         s_keep,
    output logic         s_ready,
    output logic         md5_newtext_o,
    output logic         md5_load_o,
    output logic [127:0] md5_data_o,
    input  logic         md5_ready_i,
    input  logic [127:0] md5_digest_i,
`ifdef MD5_CTRL_BYTE_OUT_EN
    output logic [7:0]   m_data,
    output logic         m_valid,
    output logic         m_last,
    input  logic         m_ready,
`else
    output logic [127:0] digest_o,
    output logic         digest_valid,
    input  logic         digest_ready,
`endif
    output logic         busy_o
);

    localparam logic [5:0] LEN_OFF   = 6'(MD5_LEN_OFFSET);
    localparam logic [5:0] LAST_OFF  = 6'(MD5_BLOCK_BYTES - 1);
    localparam logic [3:0] BEAT_LAST = 4'(MD5_BEAT_BYTES - 1);

    md5_state_e       state_q, state_d;
    logic [5:0]       offset_q, offset_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             pad80_q, pad80_d;   // 0x80 already written
    logic             late80_q, late80_d; // 0x80 landed at offset >= 56 in this block
    logic             final_q, final_d;   // current block carries the length
    logic             in_pad_q, in_pad_d; // message ended, padding outstanding
    logic             s_ready_q, s_ready_d;
    logic             newtext_q, newtext_d;
    logic             load_q, load_d;
    logic [127:0]     data_q, data_d;
    logic             busy_q, busy_d;
    logic [127:0]     digest_q, digest_d;
    logic             out_valid_q, out_valid_d;
`ifdef MD5_CTRL_BYTE_OUT_EN
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_last_q, m_last_d;
`endif

    logic             hs_s;
    logic             out_done_s;
    logic             pk_wr_s;
    logic [7:0]       pk_byte_s;
    logic             pk_clr_s;
    logic [127:0]     pk_beat_s;
    logic             pk_full_s;
    logic [63:0]      bitlen_s;

    assign hs_s     = s_valid & s_ready_q;
    assign bitlen_s = 64'(count_q) << 3'd3;

    md5_beat_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .wr_en_i (pk_wr_s),
        .lane_i  (offset_q[3:0]),
        .byte_i  (pk_byte_s),
        .clr_i   (pk_clr_s),
        .beat_o  (pk_beat_s),
        .full_o  (pk_full_s)
    );

    // Next-state, datapath and output decode for the sequencer.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        count_d     = count_q;
        pad80_d     = pad80_q;
        late80_d    = late80_q;
        final_d     = final_q;
        in_pad_d    = in_pad_q;
        newtext_d   = 1'b0;
        load_d      = 1'b0;
        data_d      = data_q;
        digest_d    = digest_q;
        out_valid_d = out_valid_q;
        out_done_s  = 1'b0;
        pk_wr_s     = 1'b0;
        pk_byte_s   = 8'h00;
        pk_clr_s    = 1'b0;
`ifdef MD5_CTRL_BYTE_OUT_EN
        idx_d       = idx_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
`endif
        case (state_q)
            ST_IDLE, ST_ACCEPT: begin
                if (hs_s) begin
                    if (state_q == ST_IDLE) begin
                        newtext_d = 1'b1;
                    end else begin
                        newtext_d = 1'b0;
                    end
                    if (s_keep) begin
                        pk_wr_s   = 1'b1;
                        pk_byte_s = s_data;
                        offset_d  = offset_q + 6'd1;
                        count_d   = count_q + LEN_W'(1);
                    end else begin
                        pk_wr_s   = 1'b0;
                    end
                    if (s_keep && (offset_q[3:0] == BEAT_LAST)) begin
                        state_d  = ST_LOAD;
                        in_pad_d = s_last;
                    end else if (s_last) begin
                        state_d  = ST_PAD;
                        in_pad_d = 1'b1;
                    end else begin
                        state_d  = ST_ACCEPT;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_PAD: begin
                pk_wr_s  = 1'b1;
                offset_d = offset_q + 6'd1;
                if (!pad80_q) begin
                    pk_byte_s = MD5_PAD_BYTE;
                    pad80_d   = 1'b1;
                    late80_d  = (offset_q >= LEN_OFF);
                end else if (!late80_q && (offset_q >= LEN_OFF)) begin
                    pk_byte_s = bitlen_s[{offset_q[2:0], 3'b000} +: 8];
                    final_d   = (offset_q == LAST_OFF);
                end else begin
                    pk_byte_s = 8'h00;
                end
                if (offset_q[3:0] == BEAT_LAST) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_PAD;
                end
            end
            ST_LOAD: begin
                load_d   = pk_full_s;
                data_d   = pk_beat_s;
                pk_clr_s = 1'b1;
                // Offset has wrapped to 0 only after the fourth beat of a block.
                if (offset_q[5:4] == 2'b00) begin
                    state_d = ST_WAIT;
                end else if (in_pad_q) begin
                    state_d = ST_PAD;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_WAIT: begin
                // Ready seen while our last load is still on the wire is stale.
                if (md5_ready_i && !load_q) begin
                    if (final_q) begin
                        digest_d    = md5_digest_i;
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT;
`ifdef MD5_CTRL_BYTE_OUT_EN
                        idx_d       = 4'd0;
                        m_data_d    = md5_digest_i[md5_lane_lsb(4'd0) +: 8];
                        m_last_d    = 1'b0;
`endif
                    end else begin
                        late80_d = 1'b0;
                        state_d  = in_pad_q ? ST_PAD : ST_ACCEPT;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_OUT: begin
`ifdef MD5_CTRL_BYTE_OUT_EN
                if (out_valid_q && m_ready) begin
                    if (idx_q == 4'd15) begin
                        out_valid_d = 1'b0;
                        m_last_d    = 1'b0;
                        out_done_s  = 1'b1;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        m_data_d = digest_q[md5_lane_lsb(idx_q + 4'd1) +: 8];
                        m_last_d = (idx_q == 4'd14);
                    end
                end else begin
                    out_done_s = 1'b0;
                end
`else
                if (out_valid_q && digest_ready) begin
                    out_valid_d = 1'b0;
                    out_done_s  = 1'b1;
                end else begin
                    out_done_s  = 1'b0;
                end
`endif
                if (out_done_s) begin
                    state_d  = ST_IDLE;
                    offset_d = 6'd0;
                    count_d  = '0;
                    pad80_d  = 1'b0;
                    late80_d = 1'b0;
                    final_d  = 1'b0;
                    in_pad_d = 1'b0;
                end else begin
                    state_d  = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCEPT);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset abandons any message in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            offset_q    <= 6'd0;
            count_q     <= '0;
            pad80_q     <= 1'b0;
            late80_q    <= 1'b0;
            final_q     <= 1'b0;
            in_pad_q    <= 1'b0;
            s_ready_q   <= 1'b0;
            newtext_q   <= 1'b0;
            load_q      <= 1'b0;
            data_q      <= 128'd0;
            busy_q      <= 1'b0;
            digest_q    <= 128'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            count_q     <= count_d;
            pad80_q     <= pad80_d;
            late80_q    <= late80_d;
            final_q     <= final_d;
            in_pad_q    <= in_pad_d;
            s_ready_q   <= s_ready_d;
            newtext_q   <= newtext_d;
            load_q      <= load_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            digest_q    <= digest_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef MD5_CTRL_BYTE_OUT_EN
    // Byte-serial digest output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q    <= 4'd0;
            m_data_q <= 8'h00;
            m_last_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            m_data_q <= m_data_d;
            m_last_q <= m_last_d;
        end
    end

    assign m_data       = m_data_q;
    assign m_valid      = out_valid_q;
    assign m_last       = m_last_q;
`else
    assign digest_o     = digest_q;
    assign digest_valid = out_valid_q;
`endif

    assign s_ready       = s_ready_q;
    assign md5_newtext_o = newtext_q;
    assign md5_load_o    = load_q;
    assign md5_data_o    = data_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_md5_stream_ctrl.sv
// Directed bench for md5_stream_ctrl with a behavioural md5 core stand-in.
module tb_md5_stream_ctrl;

    localparam int LAT = 20;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   s_data;
    logic         s_valid, s_last, s_keep;
    logic         s_ready;
    logic         md5_newtext_o, md5_load_o;
    logic [127:0] md5_data_o;
    logic         md5_ready_i;
    logic [127:0] md5_digest_i;
    logic         busy_o;
`ifdef MD5_CTRL_BYTE_OUT_EN
    logic [7:0]   m_data;
    logic         m_valid, m_last, m_ready;
`else
    logic [127:0] digest_o;
    logic         digest_valid, digest_ready;
`endif

    always #5 clk = ~clk;

    md5_stream_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_keep        (s_keep),
        .s_ready       (s_ready),
        .md5_newtext_o (md5_newtext_o),
        .md5_load_o    (md5_load_o),
        .md5_data_o    (md5_data_o),
        .md5_ready_i   (md5_ready_i),
        .md5_digest_i  (md5_digest_i),
`ifdef MD5_CTRL_BYTE_OUT_EN
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .m_ready       (m_ready),
`else
        .digest_o      (digest_o),
        .digest_valid  (digest_valid),
        .digest_ready  (digest_ready),
`endif
        .busy_o        (busy_o)
    );

    // Core stand-in: ready drops after the 4th beat of a block, returns LAT cycles later.
    logic         core_ready_q;
    logic [127:0] core_digest;
    int           lat_cnt = 0, blk_loads = 0;
    int           newtext_cnt = 0, load_cnt = 0, proto_err = 0;
    logic [127:0] beats[$];

    assign md5_ready_i  = core_ready_q;
    assign md5_digest_i = core_ready_q ? core_digest : 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

    always @(posedge clk) begin
        if (!reset) begin
            core_ready_q <= 1'b1;
            blk_loads = 0;
            lat_cnt   = 0;
        end else begin
            if (md5_newtext_o) newtext_cnt++;
            if (md5_newtext_o && md5_load_o) proto_err++;
            if (md5_load_o) begin
                if (!core_ready_q) proto_err++;
                load_cnt++;
                beats.push_back(md5_data_o);
                blk_loads++;
                if (blk_loads == 4) begin
                    blk_loads = 0;
                    core_ready_q <= 1'b0;
                    lat_cnt = LAT;
                end
            end else if (!core_ready_q) begin
                if (lat_cnt <= 1) core_ready_q <= 1'b1;
                else lat_cnt--;
            end
        end
    end

    int total = 0;
    int bad = 0;
    logic [7:0] msg_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic build(input string m, input int rep);
        msg_q.delete();
        for (int r = 0; r < rep; r++)
            for (int c = 0; c < m.len(); c++) msg_q.push_back(8'(m[c]));
    endtask

    // Present the message one byte per handshake; empty message is one keep=0 beat.
    task automatic send_msg(input bit gaps);
        int n, t;
        n = (msg_q.size() == 0) ? 1 : msg_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (gaps && i > 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_keep  = (msg_q.size() != 0);
            s_data  = (msg_q.size() != 0) ? msg_q[i] : 8'h00;
            s_last  = (i == n - 1);
            t = 0;
            while (!s_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                fail("s_ready_wait");
                s_valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Collect the digest from whichever output port this build has.
    task automatic get_digest(input int hold, output logic [127:0] got);
        int t, herr, lerr;
        logic [127:0] first;
        got = 128'd0;
        herr = 0;
        lerr = 0;
`ifdef MD5_CTRL_BYTE_OUT_EN
        for (int i = 0; i < 16; i++) begin
            t = 0;
            while (!m_valid && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 3000) begin
                fail("m_valid_wait");
                return;
            end
            if (i == 0 && hold > 0) begin
                first = 128'(m_data);
                repeat (hold) begin
                    @(negedge clk);
                    if (128'(m_data) !== first || !m_valid || s_ready) herr++;
                end
                chk("hold_stable", 128'(herr), 128'd0);
            end
            if (m_last !== (i == 15)) lerr++;
            got[96 - 32 * (i / 4) + 8 * (i % 4) +: 8] = m_data;
            m_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            m_ready = 1'b0;
        end
        chk("m_last", 128'(lerr), 128'd0);
        chk("valid_after", 128'(m_valid), 128'd0);
`else
        t = 0;
        while (!digest_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            fail("digest_valid_wait");
            return;
        end
        first = digest_o;
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                if (digest_o !== first || !digest_valid || s_ready) herr++;
            end
            chk("hold_stable", 128'(herr), 128'd0);
        end
        got = digest_o;
        digest_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        digest_ready = 1'b0;
        chk("valid_after", 128'(digest_valid), 128'd0);
`endif
    endtask

    task automatic run_case(input string m, input int rep, input bit gaps, input int hold,
                            input int exp_loads, input logic [31:0] exp_w0,
                            input logic [31:0] exp_len, input logic [127:0] dig);
        int nt0, ld0, pe0, b0, nb, mism;
        longint bl;
        logic [7:0] p[$];
        logic [127:0] e, got;
        build(m, rep);
        core_digest = dig;
        nt0 = newtext_cnt;
        ld0 = load_cnt;
        pe0 = proto_err;
        b0  = beats.size();
        send_msg(gaps);
        get_digest(hold, got);
        chk("digest", got, dig);
        chk("newtext_cnt", 128'(newtext_cnt - nt0), 128'd1);
        chk("load_cnt", 128'(load_cnt - ld0), 128'(exp_loads));
        chk("protocol", 128'(proto_err - pe0), 128'd0);
        chk("busy_after", 128'(busy_o), 128'd0);
        if (beats.size() >= b0 + exp_loads && exp_loads > 0) begin
            chk("first_word", 128'(beats[b0][127:96]), 128'(exp_w0));
            chk("len_word", 128'(beats[b0 + exp_loads - 1][63:32]), 128'(exp_len));
        end else begin
            fail("beats_missing");
        end
        // Reference padding: msg, 0x80, zeros to 56 mod 64, 64-bit LE bit length.
        p = msg_q;
        bl = longint'(msg_q.size()) * 8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(8'(bl >> (8 * i)));
        nb = p.size() / 16;
        mism = 0;
        if (beats.size() - b0 != nb) begin
            mism++;
        end else begin
            for (int n = 0; n < nb; n++) begin
                for (int w = 0; w < 4; w++)
                    e[127 - 32 * w -: 32] = {p[16*n+4*w+3], p[16*n+4*w+2], p[16*n+4*w+1], p[16*n+4*w]};
                if (beats[b0 + n] !== e) mism++;
            end
        end
        chk("beats_model", 128'(mism), 128'd0);
    endtask

    typedef struct {
        string        msg;
        int           rep;
        int           loads;
        logic [31:0]  w0;
        logic [31:0]  len_lo;
        logic [127:0] dig;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ld0, t;
        vecs[0] = '{"", 1, 4, 32'h00000080, 32'h00000000, 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec};
        vecs[1] = '{"abc", 1, 4, 32'h80636261, 32'h00000018, 128'h98500190_b04fd23c_7d3f96d6_727fe128};
        vecs[2] = '{"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 1, 8, 32'h64636261,
                    32'h000001c0, 128'h07ef1582_ca0ba296_d316e1aa_4a666c87};
        vecs[3] = '{"a", 55, 4, 32'h61616161, 32'h000001b8, 128'h01234567_89abcdef_fedcba98_76543210};
        vecs[4] = '{"abcdefgh", 8, 8, 32'h64636261, 32'h00000200, 128'hcafef00d_12345678_0badc0de_a5a5a5a5};
        vecs[5] = '{"abcdefgh", 2, 4, 32'h64636261, 32'h00000080, 128'h11112222_33334444_55556666_77778888};

        reset = 1'b0;
        s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; s_keep = 1'b0;
        core_digest = 128'd0;
`ifdef MD5_CTRL_BYTE_OUT_EN
        m_ready = 1'b0;
`else
        digest_ready = 1'b0;
`endif
        #1;
        chk("rst_ctrl", 128'({s_ready, md5_newtext_o, md5_load_o, busy_o}), 128'd0);
        chk("rst_data", md5_data_o, 128'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 128'(s_ready), 128'd1);

        for (int v = 0; v < 6; v++)
            run_case(vecs[v].msg, vecs[v].rep, 1'b0, 0, vecs[v].loads, vecs[v].w0, vecs[v].len_lo, vecs[v].dig);

        // Gappy input plus a stalled consumer.
        run_case("abc", 1, 1'b1, 10, 4, 32'h80636261, 32'h00000018,
                 128'h98500190_b04fd23c_7d3f96d6_727fe128);

        // Reset while waiting for the core, then a clean message.
        build("abc", 1);
        core_digest = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
        ld0 = load_cnt;
        send_msg(1'b0);
        t = 0;
        while (load_cnt - ld0 < 4 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) fail("wait_reach");
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_ctrl", 128'({s_ready, md5_newtext_o, md5_load_o, busy_o}), 128'd0);
        chk("midrst_data", md5_data_o, 128'd0);
`ifdef MD5_CTRL_BYTE_OUT_EN
        chk("midrst_out", 128'({m_data, m_valid, m_last}), 128'd0);
`else
        chk("midrst_out", digest_o, 128'd0);
        chk("midrst_valid", 128'(digest_valid), 128'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_midrst", 128'(s_ready), 128'd1);
        run_case("abc", 1, 1'b0, 0, 4, 32'h80636261, 32'h00000018,
                 128'h98500190_b04fd23c_7d3f96d6_727fe128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
